// File: rtl/m92_pkg.sv
// m92 shared ROM helpers.
// Address mapping and line slicing used by rom_loader and rom_reader.
package m92_pkg;

  localparam int unsigned LINE_W = 64;

  // 64-byte block reorder: logical bit 6 lands on physical bit 2
  function automatic logic [24:0] rom_reorder_64(
    input logic [24:0] off
  );
    return {off[24:7], off[5:2], off[6], off[1:0]};
  endfunction

  // 16-bit word n of a cached line, even byte in the low half
  function automatic logic [15:0] line_word(
    input logic [LINE_W-1:0] line,
    input logic [1:0]        idx
  );
    return line[{idx, 4'b0} +: 16];
  endfunction

endpackage

// File: rtl/rom_reader.sv
// rom_reader: 16-bit read client for SDRAM-resident ROM regions.
// Single-line 64-bit cache in front of a toggle req/ack line fetch.
module rom_reader
  import m92_pkg::*;
#(
  parameter logic [24:0] BASE_ADDR  = 25'd0,
  parameter bit          REORDER_64 = 1'b0
) (
  input  logic        ram_clk,
  input  logic        reset_n,
  input  logic        rd_req,
  input  logic [23:0] rd_addr,
  output logic [15:0] rd_data,
  output logic        rd_valid,
  output logic        busy,
  input  logic        flush,
  output logic [24:0] sdr_addr,
  output logic        sdr_req,
  input  logic        sdr_ack,
  input  logic [63:0] sdr_q
);

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    RESP
  } state_e;

  state_e        state_q;
  logic [63:0]   line_q;
  logic [21:0]   tag_q;
  logic          valid_q;
  logic [1:0]    widx_q;
  logic [21:0]   ntag_q;
  logic          fseen_q;
  logic [15:0]   data_q;
  logic          rvalid_q;
  logic          busy_q;
  logic [24:0]   saddr_q;
  logic          sreq_q;

  logic [24:0]   off_d;
  logic [24:0]   phys_d;
  logic          hit_d;
  logic          unused_bit;

  // Logical-to-physical translation and tag compare
  always_comb begin
    off_d  = {1'b0, rd_addr};
    phys_d = BASE_ADDR
           + (REORDER_64 ? rom_reorder_64(off_d) : off_d);
    hit_d  = valid_q
           && (tag_q == phys_d[24:3])
           && !flush;
  end

  assign unused_bit = phys_d[0];

  // Cache/fetch FSM with registered outputs
  always_ff @(posedge ram_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      line_q   <= '0;
      tag_q    <= '0;
      valid_q  <= 1'b0;
      widx_q   <= '0;
      ntag_q   <= '0;
      fseen_q  <= 1'b0;
      data_q   <= '0;
      rvalid_q <= 1'b0;
      busy_q   <= 1'b0;
      saddr_q  <= '0;
      sreq_q   <= 1'b0;
    end else begin
      rvalid_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (flush) valid_q <= 1'b0;
          if (rd_req) begin
            if (hit_d) begin
              data_q   <= line_word(line_q, phys_d[2:1]);
              rvalid_q <= 1'b1;
            end else begin
              saddr_q <= {phys_d[24:3], 3'b000};
              sreq_q  <= ~sreq_q;
              widx_q  <= phys_d[2:1];
              ntag_q  <= phys_d[24:3];
              fseen_q <= 1'b0;
              busy_q  <= 1'b1;
              state_q <= FETCH;
            end
          end
        end
        FETCH: begin
          if (flush) fseen_q <= 1'b1;
          if (sdr_ack == sreq_q) begin
            line_q  <= sdr_q;
            tag_q   <= ntag_q;
            valid_q <= ~(fseen_q | flush);
            state_q <= RESP;
          end
        end
        RESP: begin
          if (flush) valid_q <= 1'b0;
          data_q   <= line_word(line_q, widx_q);
          rvalid_q <= 1'b1;
          busy_q   <= 1'b0;
          state_q  <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign rd_data  = data_q;
  assign rd_valid = rvalid_q;
  assign busy     = busy_q;
  assign sdr_addr = saddr_q;
  assign sdr_req  = sreq_q;

endmodule
